// File: rtl/reg_mux_stage_checker.sv
// reg_mux_stage_checker
// Response checker for one DSP48A1 input/pipeline register stage. It keeps a
// shadow copy of the LAT-deep stage pipeline (LAT=0 is the bypass mux path).
// It compares the stage output against that copy every cycle while checking.
// It counts compares and mismatches, and latches the first failing pair.
module reg_mux_stage_checker #(
   parameter int    WIDTH   = 18,
   parameter int    LAT     = 1,
   parameter string RSTTYPE = "SYNC",
   parameter int    CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             stop,
   input  logic             stage_ce,
   input  logic             stage_rst,
   input  logic [WIDTH-1:0] stim_in,
   input  logic [WIDTH-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic             fail,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got
);

   // LAT=0 still gets one (unused) shadow slot so the arrays stay legal
   localparam int DEPTH    = (LAT > 0) ? LAT : 1;
   localparam bit IS_ASYNC = (RSTTYPE == "ASYNC");

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [DEPTH-1:0][WIDTH-1:0] sh_q, sh_d;
   logic [DEPTH-1:0]            v_q, v_d;
   logic                        mismatch_q, mismatch_d;
   logic                        fail_q, fail_d;
   logic [CNT_W-1:0]            chk_cnt_q, chk_cnt_d;
   logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]            first_exp_q, first_exp_d;
   logic [WIDTH-1:0]            first_got_q, first_got_d;
   logic [WIDTH-1:0]            expected;
   logic                        exp_valid;
   logic                        clear;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // Expected stage output: last shadow slot, or the live input in bypass mode.
   // An async stage reset zeroes the real output at once, so mirror that.
   always_comb begin
      expected  = (LAT == 0) ? stim_in : sh_q[DEPTH-1];
      exp_valid = (LAT == 0) ? 1'b1 : v_q[DEPTH-1];
      if (IS_ASYNC && (LAT > 0) && stage_rst) expected = '0;
   end

   // Shadow pipeline: stage reset beats CE; a (re)start clears everything
   always_comb begin
      sh_d = sh_q;
      v_d  = v_q;
      if (LAT > 0) begin
         if (stage_rst) begin
            // the stage output is a known 0 after reset, so it counts as valid
            sh_d = '0;
            v_d  = '1;
         end else if (stage_ce) begin
            sh_d[0] = stim_in;
            v_d[0]  = 1'b1;
            for (int i = 1; i < DEPTH; i++) begin
               sh_d[i] = sh_q[i-1];
               v_d[i]  = v_q[i-1];
            end
         end
      end
      if (clear) begin
         sh_d = '0;
         v_d  = '0;
      end
   end

   // Control FSM plus compare/count/first-failure capture
   always_comb begin
      state_d     = state_q;
      clear       = 1'b0;
      mismatch_d  = 1'b0;
      fail_d      = fail_q;
      chk_cnt_d   = chk_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_exp_d = first_exp_q;
      first_got_d = first_got_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FILL;
               clear   = 1'b1;
            end
         end
         S_FILL: begin
            if (start) begin
               state_d = S_FILL;
               clear   = 1'b1;
            end else if (stop) begin
               state_d = S_DONE;
            end else if (exp_valid) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (start) begin
               state_d = S_FILL;
               clear   = 1'b1;
            end else if (stop) begin
               state_d = S_DONE;
            end else begin
               chk_cnt_d = sat_inc(chk_cnt_q);
               if (dut_out != expected) begin
                  mismatch_d = 1'b1;
                  err_cnt_d  = sat_inc(err_cnt_q);
                  fail_d     = 1'b1;
                  if (!fail_q) begin
                     first_exp_d = expected;
                     first_got_d = dut_out;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clear) begin
         mismatch_d  = 1'b0;
         fail_d      = 1'b0;
         chk_cnt_d   = '0;
         err_cnt_d   = '0;
         first_exp_d = '0;
         first_got_d = '0;
      end
   end

   // State and result registers, cleared asynchronously by RST
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         sh_q        <= '0;
         v_q         <= '0;
         mismatch_q  <= 1'b0;
         fail_q      <= 1'b0;
         chk_cnt_q   <= '0;
         err_cnt_q   <= '0;
         first_exp_q <= '0;
         first_got_q <= '0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         v_q         <= v_d;
         mismatch_q  <= mismatch_d;
         fail_q      <= fail_d;
         chk_cnt_q   <= chk_cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_exp_q <= first_exp_d;
         first_got_q <= first_got_d;
      end
   end

   assign busy      = (state_q == S_FILL) || (state_q == S_CHECK);
   assign done      = (state_q == S_DONE);
   assign mismatch  = mismatch_q;
   assign fail      = fail_q;
   assign chk_cnt   = chk_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign first_exp = first_exp_q;
   assign first_got = first_got_q;

endmodule

// File: tb/tb_reg_mux_stage_checker.sv
// Bench for reg_mux_stage_checker: five checker instances share one stimulus
// stream, each watching its own behavioural model of a stage.
//   0: LAT=1 SYNC     1: LAT=2 SYNC (optionally ignores CE)
//   2: LAT=1 ASYNC    3: LAT=0 bypass    4: LAT=1 SYNC, 3-bit counters
module tb_reg_mux_stage_checker;
   localparam int W = 18;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         start = 1'b0, stop = 1'b0, ce = 1'b0, srst = 1'b0;
   logic [W-1:0] stim = '0;
   logic         flip = 1'b0, sat_flip = 1'b0, ign_ce = 1'b0;
   logic [W-1:0] s0 = '0, s1a = '0, s1b = '0, s2 = '0;
   logic [W-1:0] dout [5];
   logic [4:0]   busy, done, mm, fail;
   logic [15:0]  chk [4];
   logic [15:0]  err [4];
   logic [2:0]   chk4, err4;
   logic [W-1:0] fexp [5];
   logic [W-1:0] fgot [5];

   int checks = 0;
   int failures = 0;

   typedef struct {int inst; logic mm;} sb_t;
   sb_t sb[$];

   always #5 CLK = ~CLK;

   // Reference stages
   always @(posedge CLK) begin
      if (srst) s0 <= '0;
      else if (ce) s0 <= stim;
      if (srst) begin
         s1a <= '0;
         s1b <= '0;
      end else if (ce || ign_ce) begin
         s1a <= stim;
         s1b <= s1a;
      end
   end

   always @(posedge CLK or posedge srst)
      if (srst) s2 <= '0;
      else if (ce) s2 <= stim;

   assign dout[0] = s0 ^ {{(W-1){1'b0}}, flip};
   assign dout[1] = s1b;
   assign dout[2] = s2;
   assign dout[3] = stim;
   assign dout[4] = s0 ^ {{(W-1){1'b0}}, sat_flip};

   reg_mux_stage_checker #(.WIDTH(W), .LAT(1), .RSTTYPE("SYNC"), .CNT_W(16)) u0 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .stage_ce(ce), .stage_rst(srst),
      .stim_in(stim), .dut_out(dout[0]), .busy(busy[0]), .done(done[0]), .mismatch(mm[0]),
      .fail(fail[0]), .chk_cnt(chk[0]), .err_cnt(err[0]), .first_exp(fexp[0]), .first_got(fgot[0]));
   reg_mux_stage_checker #(.WIDTH(W), .LAT(2), .RSTTYPE("SYNC"), .CNT_W(16)) u1 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .stage_ce(ce), .stage_rst(srst),
      .stim_in(stim), .dut_out(dout[1]), .busy(busy[1]), .done(done[1]), .mismatch(mm[1]),
      .fail(fail[1]), .chk_cnt(chk[1]), .err_cnt(err[1]), .first_exp(fexp[1]), .first_got(fgot[1]));
   reg_mux_stage_checker #(.WIDTH(W), .LAT(1), .RSTTYPE("ASYNC"), .CNT_W(16)) u2 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .stage_ce(ce), .stage_rst(srst),
      .stim_in(stim), .dut_out(dout[2]), .busy(busy[2]), .done(done[2]), .mismatch(mm[2]),
      .fail(fail[2]), .chk_cnt(chk[2]), .err_cnt(err[2]), .first_exp(fexp[2]), .first_got(fgot[2]));
   reg_mux_stage_checker #(.WIDTH(W), .LAT(0), .RSTTYPE("SYNC"), .CNT_W(16)) u3 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .stage_ce(ce), .stage_rst(srst),
      .stim_in(stim), .dut_out(dout[3]), .busy(busy[3]), .done(done[3]), .mismatch(mm[3]),
      .fail(fail[3]), .chk_cnt(chk[3]), .err_cnt(err[3]), .first_exp(fexp[3]), .first_got(fgot[3]));
   reg_mux_stage_checker #(.WIDTH(W), .LAT(1), .RSTTYPE("SYNC"), .CNT_W(3)) u4 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .stage_ce(ce), .stage_rst(srst),
      .stim_in(stim), .dut_out(dout[4]), .busy(busy[4]), .done(done[4]), .mismatch(mm[4]),
      .fail(fail[4]), .chk_cnt(chk4), .err_cnt(err4), .first_exp(fexp[4]), .first_got(fgot[4]));

   // Queue the mismatch pulse expected from the cycle now being driven
   task automatic expect_mm(input int inst, input logic m);
      sb_t e;
      e.inst = inst;
      e.mm   = m;
      sb.push_back(e);
   endtask

   // Advance one cycle, then retire every pulse expectation queued for it
   task automatic step();
      sb_t e;
      @(posedge CLK);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (mm[e.inst] !== e.mm) begin
            failures++;
            $display("FAIL mismatch_pulse inst=%0d got=%b want=%b t=%0t", e.inst, mm[e.inst], e.mm, $time);
         end
      end
   endtask

   // start pulse (CE on), then 'fill' CE cycles of random data
   task automatic restart(input int fill);
      start = 1'b1; ce = 1'b1; stim = W'($urandom());
      step();
      start = 1'b0;
      repeat (fill) begin
         stim = W'($urandom());
         step();
      end
   endtask

   task automatic test_reset();
      #1 RST = 1'b1;
      step();
      checks++; if (busy !== 5'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 5'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (fail !== 5'b0 || mm !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b/%b want=0", fail, mm); end
      checks++; if (chk[0] !== 16'd0 || err[0] !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d want=0", chk[0], err[0]); end
      checks++; if (fexp[0] !== '0 || fgot[0] !== '0) begin failures++; $display("FAIL reset_first got=%h/%h want=0", fexp[0], fgot[0]); end
      RST = 1'b0;
      step();
   endtask

   task automatic test_sync_stream();
      srst = 1'b0; ce = 1'b0; start = 1'b1;
      step();
      start = 1'b0; srst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k >= 2) expect_mm(0, 1'b0);
         step();
      end
      srst = 1'b0; ce = 1'b1;
      for (int k = 0; k < 10; k++) begin
         stim = W'($urandom());
         expect_mm(0, 1'b0);
         step();
      end
      ce = 1'b0;
      repeat (2) begin expect_mm(0, 1'b0); step(); end
      checks++; if (!(chk[0] >= 16'd19)) begin failures++; $display("FAIL sync_chk_cnt got=%0d want>=19", chk[0]); end
      checks++; if (err[0] !== 16'd0) begin failures++; $display("FAIL sync_err_cnt got=%0d want=0", err[0]); end
      checks++; if (fail[0] !== 1'b0) begin failures++; $display("FAIL sync_fail got=%b want=0", fail[0]); end
   endtask

   task automatic test_single_error();
      logic [W-1:0] bad;
      bad = '0;
      restart(2);
      for (int j = 0; j < 6; j++) begin
         stim = W'($urandom());
         flip = (j == 2);
         if (flip) bad = s0;
         expect_mm(0, flip);
         step();
      end
      flip = 1'b0;
      checks++; if (chk[0] !== 16'd6) begin failures++; $display("FAIL err1_chk_cnt got=%0d want=6", chk[0]); end
      checks++; if (err[0] !== 16'd1) begin failures++; $display("FAIL err1_err_cnt got=%0d want=1", err[0]); end
      checks++; if (fail[0] !== 1'b1) begin failures++; $display("FAIL err1_fail got=%b want=1", fail[0]); end
      checks++; if (fexp[0] !== bad) begin failures++; $display("FAIL err1_first_exp got=%h want=%h", fexp[0], bad); end
      checks++; if (fgot[0] !== (bad ^ 18'd1)) begin failures++; $display("FAIL err1_first_got got=%h want=%h", fgot[0], bad ^ 18'd1); end
   endtask

   task automatic test_ce_hold();
      restart(3);
      for (int j = 0; j < 11; j++) begin
         ce = !(j >= 4 && j < 7);
         stim = W'($urandom());
         expect_mm(1, 1'b0);
         step();
      end
      checks++; if (err[1] !== 16'd0) begin failures++; $display("FAIL ce_hold_err got=%0d want=0", err[1]); end
      checks++; if (chk[1] !== 16'd11) begin failures++; $display("FAIL ce_hold_chk got=%0d want=11", chk[1]); end
      ign_ce = 1'b1;
      restart(3);
      for (int j = 0; j < 5; j++) begin
         ce = (j < 2);
         stim = W'(100 + 7 * j);
         step();
      end
      ign_ce = 1'b0; ce = 1'b1;
      checks++; if (!(err[1] >= 16'd1)) begin failures++; $display("FAIL ce_ignore_err got=%0d want>=1", err[1]); end
   endtask

   task automatic test_async_rst();
      restart(2);
      for (int j = 0; j < 4; j++) begin stim = W'($urandom()); expect_mm(2, 1'b0); step(); end
      srst = 1'b1; stim = W'($urandom()); expect_mm(2, 1'b0);
      step();
      srst = 1'b0;
      for (int j = 0; j < 4; j++) begin stim = W'($urandom()); expect_mm(2, 1'b0); step(); end
      checks++; if (err[2] !== 16'd0) begin failures++; $display("FAIL async_err got=%0d want=0", err[2]); end
      checks++; if (chk[2] !== 16'd9) begin failures++; $display("FAIL async_chk got=%0d want=9", chk[2]); end
   endtask

   task automatic test_bypass_stop();
      restart(1);
      for (int j = 0; j < 6; j++) begin stim = W'($urandom()); expect_mm(3, 1'b0); step(); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++; if (done[3] !== 1'b1 || busy[3] !== 1'b0) begin failures++; $display("FAIL bypass_done got=%b/%b want=1/0", done[3], busy[3]); end
      checks++; if (chk[3] !== 16'd6) begin failures++; $display("FAIL bypass_chk got=%0d want=6", chk[3]); end
      repeat (3) begin stim = W'($urandom()); step(); end
      checks++; if (chk[3] !== 16'd6 || err[3] !== 16'd0) begin failures++; $display("FAIL bypass_hold got=%0d/%0d want=6/0", chk[3], err[3]); end
      checks++; if (done[3] !== 1'b1) begin failures++; $display("FAIL bypass_done_hold got=%b want=1", done[3]); end
   endtask

   task automatic test_saturation();
      logic [W-1:0] first;
      first = '0;
      restart(2);
      for (int j = 0; j < 10; j++) begin
         stim = W'($urandom());
         sat_flip = 1'b1;
         if (j == 0) first = s0;
         expect_mm(4, 1'b1);
         step();
      end
      sat_flip = 1'b0;
      checks++; if (chk4 !== 3'd7 || err4 !== 3'd7) begin failures++; $display("FAIL sat_cnt got=%0d/%0d want=7/7", chk4, err4); end
      checks++; if (fail[4] !== 1'b1) begin failures++; $display("FAIL sat_fail got=%b want=1", fail[4]); end
      checks++; if (fexp[4] !== first || fgot[4] !== (first ^ 18'd1)) begin
         failures++; $display("FAIL sat_first got=%h/%h want=%h/%h", fexp[4], fgot[4], first, first ^ 18'd1);
      end
   endtask

   task automatic test_rst_midrun();
      restart(2);
      flip = 1'b1;
      repeat (2) begin stim = W'($urandom()); step(); end
      flip = 1'b0;
      step();
      checks++; if (err[0] !== 16'd2) begin failures++; $display("FAIL midrun_pre_err got=%0d want=2", err[0]); end
      #2 RST = 1'b1;
      #1;
      checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0 || fail[0] !== 1'b0 || mm[0] !== 1'b0) begin
         failures++; $display("FAIL midrun_flags got=%b%b%b%b want=0000", busy[0], done[0], fail[0], mm[0]);
      end
      checks++; if (chk[0] !== 16'd0 || err[0] !== 16'd0) begin failures++; $display("FAIL midrun_cnt got=%0d/%0d want=0", chk[0], err[0]); end
      checks++; if (fexp[0] !== '0 || fgot[0] !== '0) begin failures++; $display("FAIL midrun_first got=%h/%h want=0", fexp[0], fgot[0]); end
      step();
      RST = 1'b0;
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      checks++; if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin failures++; $display("FAIL start_over_stop got=%b/%b want=1/0", busy[0], done[0]); end
   endtask

   initial begin
      test_reset();
      test_sync_stream();
      test_single_error();
      test_ce_hold();
      test_async_rst();
      test_bypass_stop();
      test_saturation();
      test_rst_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
